bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the main bus; legal range 2-8.
REQ-002 Parameter BUS_DATA_WIDTH, default 64: main bus data width.
REQ-003 Parameter BUS_TAG_WIDTH, default 13: main bus tag width.
REQ-004 Parameter WDOG_CYCLES, default 1024: watchdog limit in cycles, used only when the watchdog is compiled in.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 abtr_reqcyc  in  NUM_REQ  per-requester bus request, level.
REQ-008 bus_busy  in  NUM_REQ  per-requester "bus in use" indication.
REQ-009 abtr_grant  out  NUM_REQ  one-hot-or-zero grant.
REQ-010 req_reqcyc / req_req / req_reqtag / req_respack  in  NUM_REQ x {1, BUS_DATA_WIDTH, BUS_TAG_WIDTH, 1}  packed per-requester bus-side signals.
REQ-011 main_bus_reqcyc / main_bus_req / main_bus_reqtag / main_bus_respack  out  {1, BUS_DATA_WIDTH, BUS_TAG_WIDTH, 1}  muxed to the system bus.
REQ-012 main_bus_respcyc  in  1; req_respcyc  out  NUM_REQ  response-cycle routed to the owner only.
REQ-013 owner_valid  out  1; owner_id  out  3  current bus owner.
REQ-014 arb_error  out  1  sticky watchdog error.

Function
REQ-015 FSM states: IDLE, GRANT, OWNED, RELEASE.
REQ-016 IDLE: if any abtr_reqcyc is high, select the first requester at or after rr_ptr (wrapping modulo NUM_REQ), then go to GRANT; otherwise stay in IDLE.
REQ-017 abtr_grant[sel] is registered and goes high on the clock edge that enters GRANT, so the grant appears 1 cycle after the request is sampled.
REQ-018 GRANT: if bus_busy[sel] is high, go to OWNED.
REQ-019 GRANT: if abtr_reqcyc[sel] is low and bus_busy[sel] is low, go to RELEASE (request withdrawn).
REQ-020 OWNED: hold the grant; go to RELEASE on the first cycle in which bus_busy[sel] is sampled low.
REQ-021 RELEASE: lasts exactly 1 cycle; grant deasserted; rr_ptr set to (sel+1) mod NUM_REQ; then go to IDLE.
REQ-022 Minimum bus turnaround between owners is 2 cycles (RELEASE, IDLE).
REQ-023 Mux behaviour in GRANT and OWNED: main_bus_* outputs are driven from requester sel, combinationally.
REQ-024 Mux behaviour in IDLE and RELEASE: main_bus_reqcyc, main_bus_respack and main_bus_req are driven 0; main_bus_reqtag is driven 0.
REQ-025 req_respcyc[sel] = main_bus_respcyc in OWNED; all other req_respcyc bits are always 0.
REQ-026 owner_valid is high in GRANT and OWNED; owner_id = sel in those states, 0 otherwise.
REQ-027 The grant is never preempted: requests from non-owners arriving during GRANT or OWNED wait.
REQ-028 A requester that has just released has the lowest priority in the next arbitration round.
REQ-029 bus_busy from non-owners is ignored.
REQ-030 Simultaneous events: a request from another requester in the cycle the owner releases is arbitrated in the next IDLE; it is never granted in RELEASE.
REQ-031 At most one abtr_grant bit is high in any cycle.

Reset
REQ-032 When reset is low, asynchronously: state=IDLE, rr_ptr=0, sel=0, abtr_grant=0, owner_valid=0, arb_error=0.
REQ-033 While reset is low, all main_bus_* and req_respcyc outputs are 0.
REQ-034 Reset asserted mid-ownership drops the grant immediately, with no RELEASE cycle.
REQ-035 On reset deassertion, the first arbitration occurs on the first rising edge that samples reset high.

Configuration
REQ-036 Macro BUS_ARBITER_WDOG_EN, when defined, adds a counter that clears on entry to OWNED and increments each OWNED cycle.
REQ-037 With the macro defined: when the counter reaches WDOG_CYCLES, the FSM forces RELEASE and sets arb_error, which stays high until reset.
REQ-038 With the macro defined: a forced release advances rr_ptr exactly as a normal release does.
REQ-039 Without the macro: no counter is built, arb_error is tied to 0, and OWNED persists indefinitely.

Verification
REQ-040 After reset, abtr_reqcyc=4'b0101 -> grant 4'b0001 one cycle later; bus_busy[0] high 3 cycles then low -> RELEASE, then grant 4'b0100 two cycles after release.
REQ-041 All four requesters held high continuously -> grant order 0,1,2,3,0 with no bit repeated before every other requester is served.
REQ-042 In GRANT, requester 2 drops abtr_reqcyc with bus_busy low -> RELEASE next cycle; rr_ptr=3; no main_bus_reqcyc pulse.
REQ-043 Owner 1 in OWNED, main_bus_respcyc=1 -> req_respcyc=4'b0010; main_bus_reqtag equals req_reqtag of requester 1.
REQ-044 Reset pulled low while requester 3 is in OWNED -> abtr_grant=0 and main_bus_reqcyc=0 in the same cycle, asynchronously.
REQ-045 With BUS_ARBITER_WDOG_EN defined and WDOG_CYCLES=16, owner holds bus_busy high -> forced release after 16 OWNED cycles and arb_error=1 sticky; without the macro, no release occurs and arb_error stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that muxes NUM_REQ requesters onto one system bus.
// Optional watchdog on bus ownership is compiled in with BUS_ARBITER_WDOG_EN.
`default_nettype none

module bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 abtr_reqcyc,
  input  logic [NUM_REQ-1:0]                 bus_busy,
  output logic [NUM_REQ-1:0]                 abtr_grant,
  input  logic [NUM_REQ-1:0]                 req_reqcyc,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0]  req_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]   req_reqtag,
  input  logic [NUM_REQ-1:0]                 req_respack,
  output logic                               main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]          main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]           main_bus_reqtag,
  output logic                               main_bus_respack,
  input  logic                               main_bus_respcyc,
  output logic [NUM_REQ-1:0]                 req_respcyc,
  output logic                               owner_valid,
  output logic [2:0]                         owner_id,
  output logic                               arb_error
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_OWNED   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("bus_arbiter: illegal parameter value");
  end

  logic [1:0]         state, next_state;
  logic [SEL_W-1:0]   sel, next_sel, rr_ptr, rr_next, pick;
  logic               found;
  logic               wdog_hit;
  logic [NUM_REQ-1:0] next_grant;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && abtr_reqcyc[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  assign rr_next = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      sel        <= '0;
      rr_ptr     <= '0;
      abtr_grant <= '0;
    end else begin
      state      <= next_state;
      sel        <= next_sel;
      abtr_grant <= next_grant;
      if (state == S_RELEASE) rr_ptr <= rr_next;
    end
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    case (state)
      S_IDLE: begin
        if (found) begin
          next_state = S_GRANT;
          next_sel   = pick;
        end
      end
      S_GRANT: begin
        if (bus_busy[sel])          next_state = S_OWNED;
        else if (!abtr_reqcyc[sel]) next_state = S_RELEASE;
      end
      S_OWNED: begin
        if (!bus_busy[sel] || wdog_hit) next_state = S_RELEASE;
      end
      default: next_state = S_IDLE;
    endcase
    next_grant = '0;
    if (next_state == S_GRANT || next_state == S_OWNED) next_grant[next_sel] = 1'b1;
  end

`ifdef BUS_ARBITER_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == S_GRANT && next_state == S_OWNED) wdog_cnt <= '0;
      else if (state == S_OWNED)                     wdog_cnt <= wdog_cnt + CNT_W'(1);
      if (wdog_hit && bus_busy[sel]) err <= 1'b1;
    end
  end

  // The limit is reached on the WDOG_CYCLES-th OWNED cycle.
  assign wdog_hit  = (state == S_OWNED) && (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));
  assign arb_error = err;
`else
  assign wdog_hit  = 1'b0;
  assign arb_error = 1'b0;
`endif

  always_comb begin
    main_bus_reqcyc  = 1'b0;
    main_bus_req     = '0;
    main_bus_reqtag  = '0;
    main_bus_respack = 1'b0;
    req_respcyc      = '0;
    owner_valid      = 1'b0;
    owner_id         = 3'd0;
    if (state == S_GRANT || state == S_OWNED) begin
      owner_valid      = 1'b1;
      owner_id         = 3'(sel);
      main_bus_reqcyc  = req_reqcyc[sel];
      main_bus_req     = req_req[sel*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      main_bus_reqtag  = req_reqtag[sel*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
      main_bus_respack = req_respack[sel];
    end
    if (state == S_OWNED) req_respcyc[sel] = main_bus_respcyc;
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (4 requesters, watchdog limit 16).
`default_nettype none

module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  abtr_reqcyc, bus_busy, abtr_grant;
  logic [N-1:0]  req_reqcyc, req_respack, req_respcyc;
  logic [N*DW-1:0] req_req;
  logic [N*TW-1:0] req_reqtag;
  logic          main_bus_reqcyc, main_bus_respack, main_bus_respcyc;
  logic [DW-1:0] main_bus_req;
  logic [TW-1:0] main_bus_reqtag;
  logic          owner_valid, arb_error;
  logic [2:0]    owner_id;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_REQ(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .abtr_reqcyc(abtr_reqcyc), .bus_busy(bus_busy), .abtr_grant(abtr_grant),
    .req_reqcyc(req_reqcyc), .req_req(req_req), .req_reqtag(req_reqtag),
    .req_respack(req_respack),
    .main_bus_reqcyc(main_bus_reqcyc), .main_bus_req(main_bus_req),
    .main_bus_reqtag(main_bus_reqtag), .main_bus_respack(main_bus_respack),
    .main_bus_respcyc(main_bus_respcyc), .req_respcyc(req_respcyc),
    .owner_valid(owner_valid), .owner_id(owner_id), .arb_error(arb_error)
  );

  function automatic logic [DW-1:0] data_of(input int i);
    return 64'hA5A5_5A5A_0000_0000 | (64'(i + 1) * 64'h1111);
  endfunction

  function automatic logic [TW-1:0] tag_of(input int i);
    return 13'h1A0 + 13'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    abtr_reqcyc = '0;
    bus_busy = '0;
    main_bus_respcyc = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    abtr_reqcyc = 4'hF;
    bus_busy = 4'hF;
    main_bus_respcyc = 1'b1;
    tick();
    tick();
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", abtr_grant); else passed++;
    checks++; if (owner_valid !== 1'b0) $display("FAIL reset_owner_valid: got %b expected 0", owner_valid); else passed++;
    checks++; if (owner_id !== 3'd0) $display("FAIL reset_owner_id: got %0d expected 0", owner_id); else passed++;
    checks++; if (main_bus_reqcyc !== 1'b0) $display("FAIL reset_reqcyc: got %b expected 0", main_bus_reqcyc); else passed++;
    checks++; if (main_bus_req !== 64'd0) $display("FAIL reset_req: got %h expected 0", main_bus_req); else passed++;
    checks++; if (main_bus_reqtag !== 13'd0) $display("FAIL reset_reqtag: got %h expected 0", main_bus_reqtag); else passed++;
    checks++; if (req_respcyc !== 4'b0000) $display("FAIL reset_respcyc: got %b expected 0000", req_respcyc); else passed++;
    checks++; if (arb_error !== 1'b0) $display("FAIL reset_arb_error: got %b expected 0", arb_error); else passed++;
    abtr_reqcyc = '0;
    bus_busy = '0;
    main_bus_respcyc = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL idle_no_req_grant: got %b expected 0000", abtr_grant); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    abtr_reqcyc = 4'b0101;
    tick();
    checks++; if (abtr_grant !== 4'b0001) $display("FAIL basic_grant0: got %b expected 0001", abtr_grant); else passed++;
    checks++; if (main_bus_req !== data_of(0)) $display("FAIL basic_req0: got %h expected %h", main_bus_req, data_of(0)); else passed++;
    bus_busy = 4'b0001;
    main_bus_respcyc = 1'b1;
    #1;
    checks++; if (req_respcyc !== 4'b0000) $display("FAIL basic_respcyc_grant: got %b expected 0000", req_respcyc); else passed++;
    repeat (3) tick();
    checks++; if (abtr_grant !== 4'b0001) $display("FAIL basic_owned_grant: got %b expected 0001", abtr_grant); else passed++;
    checks++; if (req_respcyc !== 4'b0001) $display("FAIL basic_respcyc_owned: got %b expected 0001", req_respcyc); else passed++;
    bus_busy = 4'b0000;
    main_bus_respcyc = 1'b0;
    tick();
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL basic_release_grant: got %b expected 0000", abtr_grant); else passed++;
    checks++; if (owner_valid !== 1'b0 || main_bus_reqcyc !== 1'b0) $display("FAIL basic_release_bus: got valid=%b reqcyc=%b expected 0 0", owner_valid, main_bus_reqcyc); else passed++;
    tick();
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL basic_idle_grant: got %b expected 0000", abtr_grant); else passed++;
    tick();
    checks++; if (abtr_grant !== 4'b0100) $display("FAIL basic_grant2: got %b expected 0100", abtr_grant); else passed++;
    checks++; if (owner_id !== 3'd2) $display("FAIL basic_owner2: got %0d expected 2", owner_id); else passed++;
  endtask

  task automatic test_withdraw();
    do_reset();
    req_reqcyc = 4'b0000;
    abtr_reqcyc = 4'b0100;
    tick();
    checks++; if (abtr_grant !== 4'b0100) $display("FAIL wd_grant2: got %b expected 0100", abtr_grant); else passed++;
    checks++; if (main_bus_reqcyc !== 1'b0) $display("FAIL wd_reqcyc: got %b expected 0", main_bus_reqcyc); else passed++;
    abtr_reqcyc = 4'b0000;
    tick();
    checks++; if (abtr_grant !== 4'b0000 || owner_valid !== 1'b0) $display("FAIL wd_release: got grant=%b valid=%b expected 0000 0", abtr_grant, owner_valid); else passed++;
    abtr_reqcyc = 4'b1100;
    tick();
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL wd_no_grant_in_release: got %b expected 0000", abtr_grant); else passed++;
    tick();
    checks++; if (abtr_grant !== 4'b1000) $display("FAIL wd_rr_ptr3: got %b expected 1000", abtr_grant); else passed++;
    req_reqcyc = 4'hF;
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] eg;
    do_reset();
    abtr_reqcyc = 4'hF;
    for (int r = 0; r < 5; r++) begin
      eg = 4'b0001 << exp_order[r];
      tick();
      checks++; if (abtr_grant !== eg) $display("FAIL rr_grant_round%0d: got %b expected %b", r, abtr_grant, eg); else passed++;
      bus_busy = 4'hF;
      tick();
      tick();
      checks++; if (abtr_grant !== eg) $display("FAIL rr_hold_round%0d: got %b expected %b", r, abtr_grant, eg); else passed++;
      bus_busy = 4'h0;
      tick();
      checks++; if (abtr_grant !== 4'b0000) $display("FAIL rr_release_round%0d: got %b expected 0000", r, abtr_grant); else passed++;
      tick();
      checks++; if (abtr_grant !== 4'b0000) $display("FAIL rr_idle_round%0d: got %b expected 0000", r, abtr_grant); else passed++;
    end
  endtask

  task automatic test_respcyc();
    do_reset();
    abtr_reqcyc = 4'b0010;
    tick();
    bus_busy = 4'b1011;
    tick();
    main_bus_respcyc = 1'b1;
    #1;
    checks++; if (req_respcyc !== 4'b0010) $display("FAIL resp_route: got %b expected 0010", req_respcyc); else passed++;
    checks++; if (main_bus_reqtag !== tag_of(1)) $display("FAIL resp_tag: got %h expected %h", main_bus_reqtag, tag_of(1)); else passed++;
    checks++; if (main_bus_req !== data_of(1)) $display("FAIL resp_req: got %h expected %h", main_bus_req, data_of(1)); else passed++;
    checks++; if (main_bus_respack !== 1'b1) $display("FAIL resp_respack: got %b expected 1", main_bus_respack); else passed++;
    checks++; if (owner_id !== 3'd1) $display("FAIL resp_owner: got %0d expected 1", owner_id); else passed++;
    bus_busy = 4'b1001;
    tick();
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL resp_nonowner_busy_ignored: got %b expected 0000", abtr_grant); else passed++;
    checks++; if (req_respcyc !== 4'b0000) $display("FAIL resp_after_release: got %b expected 0000", req_respcyc); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    abtr_reqcyc = 4'b1000;
    tick();
    bus_busy = 4'b1000;
    main_bus_respcyc = 1'b1;
    tick();
    checks++; if (abtr_grant !== 4'b1000 || main_bus_reqcyc !== 1'b1) $display("FAIL ar_owned: got grant=%b reqcyc=%b expected 1000 1", abtr_grant, main_bus_reqcyc); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL ar_grant: got %b expected 0000", abtr_grant); else passed++;
    checks++; if (main_bus_reqcyc !== 1'b0) $display("FAIL ar_reqcyc: got %b expected 0", main_bus_reqcyc); else passed++;
    checks++; if (owner_valid !== 1'b0 || owner_id !== 3'd0) $display("FAIL ar_owner: got valid=%b id=%0d expected 0 0", owner_valid, owner_id); else passed++;
    checks++; if (req_respcyc !== 4'b0000) $display("FAIL ar_respcyc: got %b expected 0000", req_respcyc); else passed++;
  endtask

  task automatic test_watchdog();
    do_reset();
    abtr_reqcyc = 4'b0001;
    tick();
    bus_busy = 4'b0001;
    tick();
    repeat (15) tick();
    checks++; if (abtr_grant !== 4'b0001 || arb_error !== 1'b0) $display("FAIL wdog_cycle16: got grant=%b err=%b expected 0001 0", abtr_grant, arb_error); else passed++;
    tick();
`ifdef BUS_ARBITER_WDOG_EN
    checks++; if (abtr_grant !== 4'b0000) $display("FAIL wdog_forced_release: got %b expected 0000", abtr_grant); else passed++;
    checks++; if (arb_error !== 1'b1) $display("FAIL wdog_error_set: got %b expected 1", arb_error); else passed++;
    tick();
    tick();
    checks++; if (abtr_grant !== 4'b0001) $display("FAIL wdog_regrant: got %b expected 0001", abtr_grant); else passed++;
    bus_busy = 4'b0000;
    abtr_reqcyc = 4'b0000;
    repeat (4) tick();
    checks++; if (arb_error !== 1'b1) $display("FAIL wdog_error_sticky: got %b expected 1", arb_error); else passed++;
`else
    checks++; if (abtr_grant !== 4'b0001) $display("FAIL nowdog_hold: got %b expected 0001", abtr_grant); else passed++;
    checks++; if (arb_error !== 1'b0) $display("FAIL nowdog_error: got %b expected 0", arb_error); else passed++;
    repeat (40) tick();
    checks++; if (abtr_grant !== 4'b0001 || owner_valid !== 1'b1) $display("FAIL nowdog_long_hold: got grant=%b valid=%b expected 0001 1", abtr_grant, owner_valid); else passed++;
    checks++; if (arb_error !== 1'b0) $display("FAIL nowdog_error_late: got %b expected 0", arb_error); else passed++;
`endif
  endtask

  initial begin
    reset = 1'b0;
    abtr_reqcyc = '0;
    bus_busy = '0;
    main_bus_respcyc = 1'b0;
    req_reqcyc = 4'hF;
    req_respack = 4'b1010;
    for (int i = 0; i < N; i++) begin
      req_req[i*DW +: DW]    = data_of(i);
      req_reqtag[i*TW +: TW] = tag_of(i);
    end
    test_reset();
    test_basic();
    test_withdraw();
    test_round_robin();
    test_respcyc();
    test_async_reset();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
